// File: rtl/jenc_byte_packer.sv
// Packs left-aligned variable-length bit beats into a JPEG byte stream.
// Applies 0xFF/0x00 stuffing, 1-bit padding on flush, and an optional EOI marker.
module jenc_byte_packer #(
  parameter int IN_W     = 52,
  parameter int ACC_W    = 64,
  parameter int EMIT_EOI = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] in_codecoeff,
  input  logic [5:0]      in_codecoeff_length,
  input  logic            in_valid,
  output logic            in_hold,
  input  logic            in_flush,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_hold,
  output logic            out_last,
  output logic            error
);
  localparam int FW = $clog2(ACC_W + 1);
  localparam bit EOI = (EMIT_EOI != 0);

  typedef enum logic [2:0] {RUN, STUFF, FLUSH, PAD, EOI_FF, EOI_D9} state_t;

  state_t          state, ret_state;
  logic [ACC_W-1:0] acc, acc_d, acc_n, beat_w;
  logic [FW-1:0]    fill, fill_d, fill_n;
  logic [FW:0]      fill_sum;
  logic [IN_W-1:0]  beat_mask;
  logic [7:0]       top, pad_byte;
  logic             free, drain, accept, bad_len, stuff_last;

  assign fill_sum = {1'b0, fill} + (FW+1)'(in_codecoeff_length);
  assign in_hold  = reset | (state != RUN) | (fill_sum > (FW+1)'(ACC_W));

  assign free     = !out_valid | !out_hold;
  assign top      = acc[ACC_W-1 -: 8];
  assign pad_byte = top | (8'hFF >> fill[2:0]);
  assign drain    = free && (state == RUN || state == FLUSH) && (fill >= FW'(8));
  assign accept   = in_valid & !in_hold;
  assign bad_len  = 32'(in_codecoeff_length) > IN_W;

  // Bits past the declared length are masked so stray low bits never leak in.
  assign beat_mask = ~({IN_W{1'b1}} >> in_codecoeff_length);
  assign beat_w    = {in_codecoeff & beat_mask, {(ACC_W-IN_W){1'b0}}};

  always_comb begin
    acc_d  = drain ? (acc << 8) : acc;
    fill_d = drain ? (fill - FW'(8)) : fill;
    acc_n  = acc_d;
    fill_n = fill_d;
    if (accept && !bad_len) begin
      acc_n  = acc_d | (beat_w >> fill_d);
      fill_n = fill_d + FW'(in_codecoeff_length);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      ret_state  <= RUN;
      acc        <= '0;
      fill       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      error      <= 1'b0;
      stuff_last <= 1'b0;
    end else begin
      acc  <= acc_n;
      fill <= fill_n;
      if (accept && bad_len) error <= 1'b1;
      if (free) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        RUN: begin
          if (drain) begin
            out_data  <= top;
            out_valid <= 1'b1;
          end
          if (drain && top == 8'hFF) begin
            state     <= STUFF;
            ret_state <= in_flush ? FLUSH : RUN;
          end else if (in_flush) begin
            state <= FLUSH;
          end
        end
        STUFF: if (free) begin
          out_data  <= 8'h00;
          out_valid <= 1'b1;
          out_last  <= stuff_last;
          state     <= ret_state;
        end
        FLUSH: begin
          if (drain) begin
            out_data  <= top;
            out_valid <= 1'b1;
            if (top == 8'hFF) begin
              state     <= STUFF;
              ret_state <= FLUSH;
            end
          end else if (fill < FW'(8)) begin
            if (fill != '0) state <= PAD;
            else            state <= EOI ? EOI_FF : RUN;
          end
        end
        PAD: if (free) begin
          out_data   <= pad_byte;
          out_valid  <= 1'b1;
          acc        <= '0;
          fill       <= '0;
          // With no EOI the scan ends on the pad byte, or on its stuff byte.
          stuff_last <= !EOI;
          out_last   <= !EOI && (pad_byte != 8'hFF);
          if (pad_byte == 8'hFF) begin
            state     <= STUFF;
            ret_state <= EOI ? EOI_FF : RUN;
          end else begin
            state <= EOI ? EOI_FF : RUN;
          end
        end
        EOI_FF: if (free) begin
          out_data  <= 8'hFF;
          out_valid <= 1'b1;
          state     <= EOI_D9;
        end
        EOI_D9: if (free) begin
          out_data  <= 8'hD9;
          out_valid <= 1'b1;
          out_last  <= 1'b1;
          acc       <= '0;
          fill      <= '0;
          state     <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
